// File: rtl/tlb_cache_pkg.sv
// tlb_cache_pkg: shared widths, load-size encodings, refill FSM states and
// the byte/half/word select and merge helpers used by the translating L1 cache.
// The optional TLB_CACHE_PERF_EN build adds hit/miss counters; the package
// itself is the same in both builds.
package tlb_cache_pkg;

  localparam int WORD_SIZE   = 32;
  localparam int LINE_SIZE   = 128;
  localparam int PAGE_WIDTH  = 20;
  localparam int TLB_ENTRIES = 4;
  localparam int TLB_PTR_W   = 2;
  localparam int NUM_LINES   = 4;
  localparam int OFFSET_W    = 4;
  localparam int INDEX_W     = 2;
  localparam int TAG_W       = WORD_SIZE - INDEX_W - OFFSET_W;

  // Base of the faulting region: any virtual address with this bit set traps.
  localparam logic [WORD_SIZE-1:0] EXC_VECTOR = 32'h8000_0000;

  typedef enum logic [1:0] {
    BYTE      = 2'd0,
    HALF      = 2'd1,
    FULL_WORD = 2'd2
  } load_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVICT  = 2'd1,
    REFILL = 2'd2
  } fsm_state_t;

  // Zero-extended load from an aligned word; misaligned halves and words
  // fall back to the aligned container.
  function automatic logic [WORD_SIZE-1:0] load_extract(
    input logic [WORD_SIZE-1:0] w,
    input logic [1:0]           off,
    input logic [1:0]           size
  );
    logic [WORD_SIZE-1:0] r;
    case (size)
      BYTE:    r = {24'b0, w[{off, 3'b000} +: 8]};
      HALF:    r = {16'b0, w[{off[1], 4'b0000} +: 16]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Merge a byte/half/word store into the existing aligned word.
  function automatic logic [WORD_SIZE-1:0] store_merge(
    input logic [WORD_SIZE-1:0] old_w,
    input logic [WORD_SIZE-1:0] val,
    input logic [1:0]           off,
    input logic [1:0]           size
  );
    logic [WORD_SIZE-1:0] r;
    r = old_w;
    case (size)
      BYTE:    r[{off, 3'b000} +: 8] = val[7:0];
      HALF:    r[{off[1], 4'b0000} +: 16] = val[15:0];
      default: r = val;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tlb_cache_if.sv
// tlb_cache_if: access, refill/eviction and store-drain signals of tlb_cache.
// With TLB_CACHE_PERF_EN defined the hit_count/miss_count outputs are added.
//
// Handshakes:
//   - valid/vaddr is a level request; results (tlb_hit, hit, read_data,
//     exception) are combinational in the same cycle.
//   - mem_req is held with a fixed mem_req_addr until a mem_res arrives whose
//     mem_res_addr equals it; other responses are ignored.
//   - mem_write is a single-cycle pulse with no back-pressure.
//   - wenable is held by the store buffer until store_success is seen at an
//     edge; store_stall marks cycles where the store could not commit.
interface tlb_cache_if;
  import tlb_cache_pkg::*;

  logic                 valid;
  logic [WORD_SIZE-1:0] vaddr;
  logic [1:0]           load_size;
  logic                 tlb_hit;
  logic                 exception;
  logic                 hit;
  logic [WORD_SIZE-1:0] read_data;
  logic                 mem_req;
  logic [WORD_SIZE-1:0] mem_req_addr;
  logic                 mem_res;
  logic [WORD_SIZE-1:0] mem_res_addr;
  logic [LINE_SIZE-1:0] mem_res_data;
  logic                 mem_write;
  logic [WORD_SIZE-1:0] mem_write_addr;
  logic [LINE_SIZE-1:0] mem_write_data;
  logic                 wenable;
  logic [WORD_SIZE-1:0] sb_addr;
  logic [WORD_SIZE-1:0] sb_value;
  logic [1:0]           sb_size;
  logic                 store_success;
  logic                 store_stall;
  fsm_state_t           state_dbg;

`ifdef TLB_CACHE_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport master (
    output valid, vaddr, load_size, mem_res, mem_res_addr, mem_res_data,
           wenable, sb_addr, sb_value, sb_size,
    input  tlb_hit, exception, hit, read_data, mem_req, mem_req_addr,
           mem_write, mem_write_addr, mem_write_data, store_success,
           store_stall, state_dbg, hit_count, miss_count
  );

  modport slave (
    input  valid, vaddr, load_size, mem_res, mem_res_addr, mem_res_data,
           wenable, sb_addr, sb_value, sb_size,
    output tlb_hit, exception, hit, read_data, mem_req, mem_req_addr,
           mem_write, mem_write_addr, mem_write_data, store_success,
           store_stall, state_dbg, hit_count, miss_count
  );
`else
  modport master (
    output valid, vaddr, load_size, mem_res, mem_res_addr, mem_res_data,
           wenable, sb_addr, sb_value, sb_size,
    input  tlb_hit, exception, hit, read_data, mem_req, mem_req_addr,
           mem_write, mem_write_addr, mem_write_data, store_success,
           store_stall, state_dbg
  );

  modport slave (
    input  valid, vaddr, load_size, mem_res, mem_res_addr, mem_res_data,
           wenable, sb_addr, sb_value, sb_size,
    output tlb_hit, exception, hit, read_data, mem_req, mem_req_addr,
           mem_write, mem_write_addr, mem_write_data, store_success,
           store_stall, state_dbg
  );
`endif

endinterface

// File: rtl/tlb_cache_tlb.sv
// tlb_cache_tlb: small fully-associative TLB. Combinational lookup on the
// virtual page; a fill request writes an identity mapping into the
// round-robin victim slot and advances the pointer.
module tlb_cache_tlb
  import tlb_cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PAGE_WIDTH-1:0] vpage,
  input  logic                  fill,
  output logic                  hit,
  output logic [PAGE_WIDTH-1:0] ppage
);

  logic [TLB_ENTRIES-1:0] ent_valid;
  logic [PAGE_WIDTH-1:0]  ent_vpage [TLB_ENTRIES];
  logic [PAGE_WIDTH-1:0]  ent_ppage [TLB_ENTRIES];
  logic [TLB_PTR_W-1:0]   rr_ptr;

  // Parallel compare of every valid entry against the requested page.
  always_comb begin
    hit   = 1'b0;
    ppage = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (ent_valid[i] && (ent_vpage[i] == vpage)) begin
        hit   = 1'b1;
        ppage = ent_ppage[i];
      end
    end
  end

  // Fill the round-robin victim with an identity translation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid <= '0;
      rr_ptr    <= '0;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        ent_vpage[i] <= '0;
        ent_ppage[i] <= '0;
      end
    end else if (fill) begin
      ent_valid[rr_ptr] <= 1'b1;
      ent_vpage[rr_ptr] <= vpage;
      ent_ppage[rr_ptr] <= vpage;
      rr_ptr            <= rr_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/tlb_cache.sv
// tlb_cache: translating, write-back, direct-mapped L1 cache. The TLB lives
// in tlb_cache_tlb; the line arrays and the IDLE/EVICT/REFILL refill FSM
// live here. Define TLB_CACHE_PERF_EN to add hit_count/miss_count outputs.
module tlb_cache
  import tlb_cache_pkg::*;
(
  input logic        clk,
  input logic        rst,
  tlb_cache_if.slave bus
);

  logic                  req_v;
  logic                  wen;
  logic                  fault;
  logic                  tlb_match;
  logic                  xlat;
  logic [PAGE_WIDTH-1:0] ppage;
  logic [WORD_SIZE-1:0]  paddr;

  logic [NUM_LINES-1:0]  line_valid;
  logic [NUM_LINES-1:0]  line_dirty;
  logic [TAG_W-1:0]      line_tag  [NUM_LINES];
  logic [LINE_SIZE-1:0]  line_data [NUM_LINES];

  logic [INDEX_W-1:0]    ld_idx;
  logic [INDEX_W-1:0]    st_idx;
  logic [TAG_W-1:0]      ld_tag;
  logic [TAG_W-1:0]      st_tag;
  logic                  ld_hit;
  logic                  st_hit;
  logic [WORD_SIZE-1:0]  ld_word;
  logic [WORD_SIZE-1:0]  st_word;

  fsm_state_t            state;
  fsm_state_t            state_next;
  logic [WORD_SIZE-1:0]  miss_addr;
  logic [INDEX_W-1:0]    miss_idx;
  logic                  start_st_miss;
  logic                  start_ld_miss;
  logic                  start_miss;
  logic [WORD_SIZE-1:0]  start_addr;
  logic [INDEX_W-1:0]    start_idx;
  logic                  victim_dirty;
  logic [WORD_SIZE-1:0]  req_addr;
  logic [INDEX_W-1:0]    req_idx;
  logic                  mem_req;
  logic                  mem_write;
  logic                  refill_done;
  logic                  store_success;

  // Requests are masked while reset is held so every output reads 0.
  assign req_v = bus.valid & ~rst;
  assign wen   = bus.wenable & ~rst;
  assign fault = req_v & (|(bus.vaddr & EXC_VECTOR));

  tlb_cache_tlb u_tlb (
    .clk   (clk),
    .rst   (rst),
    .vpage (bus.vaddr[WORD_SIZE-1 -: PAGE_WIDTH]),
    .fill  (req_v & ~fault & ~tlb_match),
    .hit   (tlb_match),
    .ppage (ppage)
  );

  assign xlat  = req_v & ~fault & tlb_match;
  assign paddr = {ppage, bus.vaddr[WORD_SIZE-PAGE_WIDTH-1:0]};

  // Load-side lookup on the translated address.
  assign ld_idx  = paddr[OFFSET_W +: INDEX_W];
  assign ld_tag  = paddr[WORD_SIZE-1 -: TAG_W];
  assign ld_hit  = xlat & line_valid[ld_idx] & (line_tag[ld_idx] == ld_tag);
  assign ld_word = line_data[ld_idx][{paddr[3:2], 5'b00000} +: WORD_SIZE];

  // Store-side lookup on the physical store-buffer address.
  assign st_idx  = bus.sb_addr[OFFSET_W +: INDEX_W];
  assign st_tag  = bus.sb_addr[WORD_SIZE-1 -: TAG_W];
  assign st_hit  = line_valid[st_idx] & (line_tag[st_idx] == st_tag);
  assign st_word = line_data[st_idx][{bus.sb_addr[3:2], 5'b00000} +: WORD_SIZE];

  // Stores commit only while no refill is in flight, so a line being evicted
  // or refilled is never modified underneath the FSM.
  assign store_success = wen & (state == IDLE) & st_hit;

  // A store miss wins over a load miss; any store activity defers a load
  // miss so a store commit and a victim choice never race on the same line.
  assign start_st_miss = wen & (state == IDLE) & ~st_hit;
  assign start_ld_miss = ~wen & (state == IDLE) & xlat & ~ld_hit;
  assign start_miss    = start_st_miss | start_ld_miss;
  assign start_idx     = start_st_miss ? st_idx : ld_idx;
  assign start_addr    = start_st_miss ? {bus.sb_addr[WORD_SIZE-1:OFFSET_W], 4'b0000}
                                       : {paddr[WORD_SIZE-1:OFFSET_W], 4'b0000};
  assign victim_dirty  = line_valid[start_idx] & line_dirty[start_idx];

  // Refill FSM next state and request outputs.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    req_addr   = miss_addr;
    req_idx    = miss_idx;
    case (state)
      IDLE: begin
        if (start_miss) begin
          req_addr = start_addr;
          req_idx  = start_idx;
          if (victim_dirty) begin
            state_next = EVICT;
          end else begin
            mem_req    = 1'b1;
            state_next = REFILL;
          end
        end
      end
      EVICT: begin
        mem_write  = 1'b1;
        state_next = REFILL;
      end
      REFILL: begin
        mem_req = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    refill_done = mem_req & bus.mem_res & (bus.mem_res_addr == req_addr);
    if (refill_done) state_next = IDLE;
  end

  // FSM state and captured miss address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      miss_addr <= '0;
      miss_idx  <= '0;
    end else begin
      state <= state_next;
      if (start_miss) begin
        miss_addr <= start_addr;
        miss_idx  <= start_idx;
      end
    end
  end

  // Line valid/dirty bits: refill installs clean, store commit marks dirty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_valid <= '0;
      line_dirty <= '0;
    end else begin
      if (refill_done) begin
        line_valid[req_idx] <= 1'b1;
        line_dirty[req_idx] <= 1'b0;
      end
      if (store_success) line_dirty[st_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (refill_done) begin
      line_tag[req_idx]  <= req_addr[WORD_SIZE-1 -: TAG_W];
      line_data[req_idx] <= bus.mem_res_data;
    end else if (store_success) begin
      line_data[st_idx][{bus.sb_addr[3:2], 5'b00000} +: WORD_SIZE] <=
        store_merge(st_word, bus.sb_value, bus.sb_addr[1:0], bus.sb_size);
    end
  end

  assign bus.tlb_hit        = xlat;
  assign bus.exception      = fault;
  assign bus.hit            = ld_hit;
  assign bus.read_data      = ld_hit ? load_extract(ld_word, paddr[1:0], bus.load_size) : '0;
  assign bus.mem_req        = mem_req;
  assign bus.mem_req_addr   = mem_req ? req_addr : '0;
  assign bus.mem_write      = mem_write;
  assign bus.mem_write_addr = mem_write ? {line_tag[miss_idx], miss_idx, 4'b0000} : '0;
  assign bus.mem_write_data = mem_write ? line_data[miss_idx] : '0;
  assign bus.store_success  = store_success;
  assign bus.store_stall    = wen & ~store_success;
  assign bus.state_dbg      = state;

`ifdef TLB_CACHE_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  // Count load hits per cycle and each newly started refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (ld_hit)     hit_cnt  <= hit_cnt + 32'd1;
      if (start_miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign bus.hit_count  = hit_cnt;
  assign bus.miss_count = miss_cnt;
`endif

endmodule

// File: tb/tb_tlb_cache.sv
// tb_tlb_cache: directed bench for tlb_cache. Inputs change just after the
// falling edge and outputs are checked 2 ns later, well away from the rising
// edge where the design updates.
module tb_tlb_cache;
  import tlb_cache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  localparam logic [LINE_SIZE-1:0] LINE_A =
    {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
  localparam logic [LINE_SIZE-1:0] LINE_B =
    {32'hB3B3_B3B3, 32'hB2B2_B2B2, 32'hB1B1_B1B1, 32'hCAFE_F00D};
  localparam logic [LINE_SIZE-1:0] LINE_C =
    {32'hC3C3_C3C3, 32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'h0C0C_0C0C};
  localparam logic [LINE_SIZE-1:0] EVICT_A =
    {32'hBEEF_3333, 32'h2222_AB22, 32'h1234_5678, 32'h1111_1111};

  tlb_cache_if bus ();

  tlb_cache dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [LINE_SIZE-1:0] obs,
                     input logic [LINE_SIZE-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.valid        = 1'b0;
    bus.vaddr        = '0;
    bus.load_size    = FULL_WORD;
    bus.mem_res      = 1'b0;
    bus.mem_res_addr = '0;
    bus.mem_res_data = '0;
    bus.wenable      = 1'b0;
    bus.sb_addr      = '0;
    bus.sb_value     = '0;
    bus.sb_size      = FULL_WORD;
  endtask

  // Drive a load for the next cycle and let combinational outputs settle.
  task automatic load(input logic [WORD_SIZE-1:0] a, input logic [1:0] sz);
    @(negedge clk);
    bus.valid     = 1'b1;
    bus.vaddr     = a;
    bus.load_size = sz;
    #2;
  endtask

  task automatic store(input logic [WORD_SIZE-1:0] a, input logic [WORD_SIZE-1:0] v,
                       input logic [1:0] sz);
    @(negedge clk);
    bus.valid    = 1'b0;
    bus.wenable  = 1'b1;
    bus.sb_addr  = a;
    bus.sb_value = v;
    bus.sb_size  = sz;
    #2;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #2;
  endtask

  // Fill a TLB entry without letting the cache start a refill: the request
  // is withdrawn before the rising edge of the translated cycle.
  task automatic tlb_touch(input logic [WORD_SIZE-1:0] a, input string tag);
    load(a, FULL_WORD);
    chk({tag, "_miss"}, bus.tlb_hit, 1'b0);
    next_cycle();
    chk({tag, "_hit"}, bus.tlb_hit, 1'b1);
    bus.valid = 1'b0;
  endtask

  initial begin
    // Reset with live requests present: everything must stay quiet.
    clear_inputs();
    rst = 1'b1;
    bus.valid   = 1'b1;
    bus.vaddr   = 32'h0000_1000;
    bus.wenable = 1'b1;
    bus.sb_addr = 32'h0000_1000;
    #2;
    chk("reset_outputs",
        {bus.tlb_hit, bus.exception, bus.hit, bus.mem_req, bus.mem_write,
         bus.store_success, bus.store_stall, bus.read_data, bus.mem_req_addr,
         bus.mem_write_addr}, '0);
    chk("reset_state", bus.state_dbg, IDLE);
    repeat (2) @(negedge clk);
    clear_inputs();
    rst = 1'b0;

    // Cold access: TLB miss, then cache miss with a line request.
    load(32'h0000_1000, FULL_WORD);
    chk("cold_tlb_miss", bus.tlb_hit, 1'b0);
    chk("cold_no_req", bus.mem_req, 1'b0);
    next_cycle();
    chk("cold_tlb_hit", bus.tlb_hit, 1'b1);
    chk("cold_cache_miss", bus.hit, 1'b0);
    chk("cold_req", bus.mem_req, 1'b1);
    chk("cold_req_addr", bus.mem_req_addr, 32'h0000_1000);

    // A response for another line is ignored.
    @(negedge clk);
    bus.mem_res      = 1'b1;
    bus.mem_res_addr = 32'h0000_2000;
    bus.mem_res_data = '1;
    #2;
    chk("refill_state", bus.state_dbg, REFILL);
    chk("req_held_wrong_res", bus.mem_req, 1'b1);
    @(negedge clk);
    bus.mem_res_addr = 32'h0000_1000;
    bus.mem_res_data = LINE_A;
    #2;
    chk("req_held_until_res", bus.mem_req, 1'b1);
    @(negedge clk);
    bus.mem_res = 1'b0;

    // Loads of every size from the refilled line.
    load(32'h0000_1004, FULL_WORD);
    chk("hit_word1", bus.hit, 1'b1);
    chk("rd_word1", bus.read_data, 32'hDEAD_BEEF);
    chk("no_req_on_hit", bus.mem_req, 1'b0);
    load(32'h0000_1005, BYTE);
    chk("rd_byte_1005", bus.read_data, 32'h0000_00BE);
    load(32'h0000_1004, BYTE);
    chk("rd_byte_1004", bus.read_data, 32'h0000_00EF);
    load(32'h0000_1004, HALF);
    chk("rd_half_1004", bus.read_data, 32'h0000_BEEF);
    load(32'h0000_1006, HALF);
    chk("rd_half_1006", bus.read_data, 32'h0000_DEAD);
    load(32'h0000_1007, HALF);
    chk("rd_half_misaligned", bus.read_data, 32'h0000_DEAD);
    load(32'h0000_1006, FULL_WORD);
    chk("rd_word_misaligned", bus.read_data, 32'hDEAD_BEEF);
    load(32'h0000_1000, FULL_WORD);
    chk("rd_word0", bus.read_data, 32'h1111_1111);

    // Translation fault: no data, no request, no TLB fill.
    load(32'h8000_0000, FULL_WORD);
    chk("exc_flag", bus.exception, 1'b1);
    chk("exc_rdata", bus.read_data, 32'h0);
    chk("exc_no_req", bus.mem_req, 1'b0);
    chk("exc_no_tlb_hit", bus.tlb_hit, 1'b0);
    next_cycle();
    chk("exc_no_fill", bus.tlb_hit, 1'b0);
    @(negedge clk);
    bus.valid = 1'b0;
    #2;
    chk("exc_needs_valid", bus.exception, 1'b0);

    // Store hits of each size.
    store(32'h0000_1004, 32'h1234_5678, FULL_WORD);
    chk("st_word_success", bus.store_success, 1'b1);
    chk("st_word_no_stall", bus.store_stall, 1'b0);
    store(32'h0000_1009, 32'h0000_00AB, BYTE);
    chk("st_byte_success", bus.store_success, 1'b1);
    store(32'h0000_100E, 32'h0000_BEEF, HALF);
    chk("st_half_success", bus.store_success, 1'b1);
    @(negedge clk);
    bus.wenable = 1'b0;
    load(32'h0000_1004, FULL_WORD);
    chk("reload_word", bus.read_data, 32'h1234_5678);
    load(32'h0000_1008, FULL_WORD);
    chk("reload_byte_merge", bus.read_data, 32'h2222_AB22);
    load(32'h0000_100C, FULL_WORD);
    chk("reload_half_merge", bus.read_data, 32'hBEEF_3333);

    // Conflict on index 0 evicts the dirty line, then refills.
    load(32'h0000_1040, FULL_WORD);
    chk("conf_tlb_hit", bus.tlb_hit, 1'b1);
    chk("conf_miss", bus.hit, 1'b0);
    chk("conf_no_req_yet", bus.mem_req, 1'b0);
    chk("conf_no_wr_yet", bus.mem_write, 1'b0);
    next_cycle();
    chk("evict_pulse", bus.mem_write, 1'b1);
    chk("evict_addr", bus.mem_write_addr, 32'h0000_1000);
    chk("evict_data", bus.mem_write_data, EVICT_A);
    chk("evict_no_req", bus.mem_req, 1'b0);
    next_cycle();
    chk("evict_one_cycle", bus.mem_write, 1'b0);
    chk("conf_req", bus.mem_req, 1'b1);
    chk("conf_req_addr", bus.mem_req_addr, 32'h0000_1040);
    @(negedge clk);
    bus.mem_res      = 1'b1;
    bus.mem_res_addr = 32'h0000_1040;
    bus.mem_res_data = LINE_B;
    #2;
    @(negedge clk);
    bus.mem_res = 1'b0;
    #2;
    chk("conf_hit", bus.hit, 1'b1);
    chk("conf_rdata", bus.read_data, 32'hCAFE_F00D);

    // Store miss and load miss together: the store's line is fetched first.
    @(negedge clk);
    bus.valid     = 1'b1;
    bus.vaddr     = 32'h0000_1050;
    bus.load_size = FULL_WORD;
    bus.wenable   = 1'b1;
    bus.sb_addr   = 32'h0000_1000;
    bus.sb_value  = 32'h0000_0055;
    bus.sb_size   = BYTE;
    #2;
    chk("stm_stall", bus.store_stall, 1'b1);
    chk("stm_no_success", bus.store_success, 1'b0);
    chk("stm_clean_victim", bus.mem_write, 1'b0);
    chk("stm_req", bus.mem_req, 1'b1);
    chk("stm_req_addr_prio", bus.mem_req_addr, 32'h0000_1000);
    @(negedge clk);
    bus.mem_res      = 1'b1;
    bus.mem_res_addr = 32'h0000_1000;
    bus.mem_res_data = LINE_A;
    #2;
    chk("stm_stall_refill", bus.store_stall, 1'b1);
    @(negedge clk);
    bus.mem_res = 1'b0;
    #2;
    chk("stm_success", bus.store_success, 1'b1);
    chk("stm_stall_clear", bus.store_stall, 1'b0);
    chk("stm_load_deferred", bus.mem_req, 1'b0);
    @(negedge clk);
    bus.wenable = 1'b0;
    #2;
    chk("ldm_req", bus.mem_req, 1'b1);
    chk("ldm_req_addr", bus.mem_req_addr, 32'h0000_1050);
    @(negedge clk);
    bus.mem_res      = 1'b1;
    bus.mem_res_addr = 32'h0000_1050;
    bus.mem_res_data = LINE_C;
    #2;
    @(negedge clk);
    bus.mem_res = 1'b0;
    #2;
    chk("ldm_hit", bus.hit, 1'b1);
    chk("ldm_rdata", bus.read_data, 32'h0C0C_0C0C);
    load(32'h0000_1000, FULL_WORD);
    chk("stm_merged", bus.read_data, 32'h1111_1155);
    @(negedge clk);
    bus.valid = 1'b0;

    // Round-robin TLB: pages 2..4 fill entries 1..3, page 5 replaces entry 0.
    tlb_touch(32'h0000_2000, "tlb_p2");
    tlb_touch(32'h0000_3000, "tlb_p3");
    tlb_touch(32'h0000_4000, "tlb_p4");
    tlb_touch(32'h0000_5000, "tlb_p5");
    load(32'h0000_1000, FULL_WORD);
    chk("tlb_p1_evicted", bus.tlb_hit, 1'b0);
    bus.valid = 1'b0;
    load(32'h0000_2000, FULL_WORD);
    chk("tlb_p2_kept", bus.tlb_hit, 1'b1);
    bus.valid = 1'b0;

    // Reset in the middle of a refill aborts it and clears all state.
    load(32'h0000_3020, FULL_WORD);
    chk("abort_req", bus.mem_req, 1'b1);
    chk("abort_req_addr", bus.mem_req_addr, 32'h0000_3020);
    next_cycle();
    chk("abort_refill_state", bus.state_dbg, REFILL);
    rst = 1'b1;
    #1;
    chk("abort_req_drop", bus.mem_req, 1'b0);
    chk("abort_state_idle", bus.state_dbg, IDLE);
    chk("abort_tlb_hit_off", bus.tlb_hit, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    load(32'h0000_1004, FULL_WORD);
    chk("post_rst_tlb_cleared", bus.tlb_hit, 1'b0);
    chk("post_rst_no_req", bus.mem_req, 1'b0);
    next_cycle();
    chk("post_rst_tlb_refill", bus.tlb_hit, 1'b1);
    chk("post_rst_cache_cleared", bus.hit, 1'b0);
    chk("post_rst_req_addr", bus.mem_req_addr, 32'h0000_1000);
    bus.valid = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
